// File: rtl/adder_pipe_nbit_pkg.sv
// adder_pipe_nbit_pkg: stage count and configuration legality for the segmented pipelined adder
package adder_pipe_nbit_pkg;
  function automatic int stages_of(input int n, input int seg);
    return (seg < 1) ? 1 : n / seg;
  endfunction
  function automatic bit legal_cfg(input int n, input int seg);
    return (seg >= 1) && (n >= seg) && (n % seg == 0);
  endfunction
endpackage

// File: rtl/adder_pipe_nbit_seg.sv
// adder_seg: combinational W-bit adder slice with carry-out and carry into its MSB
module adder_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  // the sum bit is a^b^carry_in, so the MSB carry-in falls out of the result
  assign c_msb = a[W-1] ^ b[W-1] ^ s[W-1];
endmodule

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: segmented pipelined add/sub, one SEG-bit slice per stage, global stall.
// Define ADDER_PIPE_FLAGS_EN to add registered Z (zero) and OVF (signed overflow) outputs.
module adder_pipe_nbit
  import adder_pipe_nbit_pkg::*;
#(
  parameter int N   = 64,
  parameter int SEG = 16
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  input  logic         Cin,
  input  logic         SUB,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] SUM,
  output logic         Cout,
`ifdef ADDER_PIPE_FLAGS_EN
  output logic         Z,
  output logic         OVF,
`endif
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int STAGES = stages_of(N, SEG);
  if (!legal_cfg(N, SEG)) begin : g_bad_cfg
    $error("adder_pipe_nbit: N must be a positive multiple of SEG");
  end
  logic         advance;
  logic [N-1:0] b_head;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_head   = SUB ? ~IN2 : IN2;
  // w carries finished result slices below the current segment and raw A above it
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic [N-1:0]   a_in, b_in, w_nx, w, b;
    logic [SEG-1:0] sum;
    logic           ci_in, v_in, v, c, co, cm;
    logic           unused_ok;
    if (s == 0) begin : g_head
      assign a_in  = IN1;
      assign b_in  = b_head;
      assign ci_in = Cin;
      assign v_in  = in_valid;
    end else begin : g_tail
      assign a_in  = g_st[s-1].w;
      assign b_in  = g_st[s-1].b;
      assign ci_in = g_st[s-1].c;
      assign v_in  = g_st[s-1].v;
    end
    adder_seg #(.W(SEG)) u_seg (
      .a    (a_in[s*SEG +: SEG]),
      .b    (b_in[s*SEG +: SEG]),
      .ci   (ci_in),
      .s    (sum),
      .co   (co),
      .c_msb(cm)
    );
    always_comb begin
      w_nx = a_in;
      w_nx[s*SEG +: SEG] = sum;
    end
    always_ff @(posedge CLK)
      if (!RST_n) begin
        v <= 1'b0;
        w <= '0;
        b <= '0;
        c <= 1'b0;
      end else if (advance) begin
        v <= v_in;
        w <= w_nx;
        b <= b_in;
        c <= co;
      end
    assign unused_ok = ^{b, cm};
  end
  assign SUM       = g_st[STAGES-1].w;
  assign Cout      = g_st[STAGES-1].c;
  assign out_valid = g_st[STAGES-1].v;
`ifdef ADDER_PIPE_FLAGS_EN
  always_ff @(posedge CLK)
    if (!RST_n) begin
      Z   <= 1'b0;
      OVF <= 1'b0;
    end else if (advance) begin
      Z   <= (g_st[STAGES-1].w_nx == '0);
      OVF <= g_st[STAGES-1].cm ^ g_st[STAGES-1].co;
    end
`endif
endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined, segmented N-bit integer adder/subtractor for the FPU datapath (mantissa add, exponent difference).
- Splits the N-bit operation into STAGES = N/SEG segments and resolves one segment per pipeline stage, carrying between stages.
- Uses valid/ready handshakes on both sides with full backpressure. Throughput is one operation per cycle; latency is STAGES cycles.

Parameters:
- N, 64, operand/result width in bits; N must be a multiple of SEG.
- SEG, 16, bits resolved per stage; SEG = N gives a single-stage registered adder.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  synchronous, active-low reset.
- IN1  in  N  operand A.
- IN2  in  N  operand B.
- Cin  in  1  carry-in. For subtraction it is the "no-borrow-in" bit; 1 gives a plain A-B.
- SUB  in  1  1: compute A + ~B + Cin; 0: compute A + B + Cin.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- SUM  out  N  result.
- Cout  out  1  carry-out of MSB. For SUB=1 it is the no-borrow flag.
- out_valid  out  1  SUM/Cout valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset (RST_n=0 at a rising edge): all stage valid bits clear; SUM=0, Cout=0, out_valid=0. in_ready=1 from the first cycle after reset. Any in-flight operations are discarded with no partial output. The data registers of non-output stages need not be reset.
- Accept: an operation is accepted when in_valid && in_ready at the rising edge.
- advance = !out_valid || out_ready.
  - When advance=1, every stage shifts forward one position.
  - When advance=0, all stages hold.
  - in_ready = advance (combinational; global-stall pipeline).
- Stage k (k = 1..STAGES) holds:
  - valid bit;
  - result segments 0..k-1 (already summed);
  - operand segments k..STAGES-1 (unsummed, B already conditionally inverted);
  - carry out of segment k-1.
- On accept, stage 1 captures:
  - segment 0 sum = A[SEG-1:0] + B'[SEG-1:0] + Cin, where B' = SUB ? ~IN2 : IN2;
  - that segment's carry;
  - the remaining operand segments.
- On advance, stage k+1 captures:
  - segment k sum of stage-k operands plus the stage-k carry;
  - the new carry;
  - shifted-through lower results.
- Stage STAGES is the output register. SUM is its concatenated result and Cout its final carry.
- Latency:
  - accept in cycle 0 gives out_valid=1 in cycle STAGES when there is no stall;
  - each stall cycle adds one.
- Output hold: while out_valid && !out_ready, SUM, Cout and out_valid are stable.
- Full pipeline, out_ready=1 and in_valid=1 in the same cycle: drain, shift and accept all happen together, with no bubble.
- Empty pipeline, out_ready=0: advance=1 because out_valid=0, so the pipeline fills until the output stage is valid, then stalls.
- Arithmetic is modulo 2^N; Cout reports wrap. Inputs are sampled only on accept, so IN1/IN2/SUB/Cin may change freely otherwise.
- Order is preserved: results are delivered in accept order, with no loss or duplication.

Optional Feature:
- Macro: ADDER_PIPE_FLAGS_EN.
- Defined: extra outputs, registered alongside SUM in the output stage and reset to 0.
  - Z (1 bit) = (SUM == 0).
  - OVF (1 bit) = signed two's-complement overflow = carry into MSB XOR carry out of MSB. The final segment's internal MSB carry is propagated for this.
- Undefined: Z and OVF are absent from the port list, and no extra flops are created.

Decomposition:
- Shared package/include file:
  - STAGES = N/SEG;
  - the parameter legality check (N % SEG == 0, SEG >= 1) as an elaboration-time error.
- One sub-module: adder_seg.
  - Purely combinational SEG-bit ripple adder with a, b, ci, s, co, and c_msb (carry into the MSB).
  - Instantiated once per stage via generate.

Test Plan:
- Carry ripple: N=64, SEG=16, IN1=0xFFFF_FFFF_FFFF_FFFF, IN2=1, Cin=0, SUB=0, out_ready=1. Expect SUM=0, Cout=1, out_valid exactly 4 cycles after accept.
- Subtract with borrow: IN1=5, IN2=7, SUB=1, Cin=1. Expect SUM=0xFFFF_FFFF_FFFF_FFFE, Cout=0. Same with IN1=7, IN2=5: expect SUM=2, Cout=1.
- Backpressure: 6 back-to-back accepts (IN1=i, IN2=0x100, i=0..5) with out_ready low for cycles 3..7.
  - in_ready drops once the output stage is valid.
  - Results 0x100..0x105 appear in order.
  - SUM is stable while stalled; no loss.
- Reset mid-operation: 3 operations in flight, RST_n=0 for one edge.
  - Next cycle: out_valid=0, SUM=0, in_ready=1.
  - No stale result ever emerges.
  - A fresh op 2+3 returns 5 after 4 cycles.
- Parameter variation: N=32, SEG=32, 0x8000_0000+0x8000_0000. Expect SUM=0, Cout=1, latency 1. With ADDER_PIPE_FLAGS_EN: Z=1, OVF=1.
- Flags: N=64, SEG=16, 0x7FFF_FFFF_FFFF_FFFF+1 with ADDER_PIPE_FLAGS_EN. Expect SUM=0x8000_0000_0000_0000, Cout=0, OVF=1, Z=0.
